// File: rtl/weight_bank_scheduler_if.sv
// weight_bank_scheduler_if: layer control, DMA beat stream, compute handshake and SRAM control
// of the double-buffered weight bank scheduler.
interface weight_bank_scheduler_if #(
   parameter int SRAM_ADDR_W = 10,
   parameter int SRAM_WIDTH  = 64
);
   logic                   start;
   logic [15:0]            num_tiles;
   logic [SRAM_ADDR_W:0]   tile_words;
   logic                   busy;
   logic                   done;
   logic                   dma_valid;
   logic [SRAM_WIDTH-1:0]  dma_data;
   logic                   dma_ready;
   logic                   cmp_tile_ready;
   logic                   cmp_start;
   logic                   sram_bank_swap;
   logic                   sram_rd_en;
   logic [SRAM_ADDR_W-1:0] sram_rd_addr;
   logic                   sram_wr_en;
   logic [SRAM_ADDR_W-1:0] sram_wr_addr;
   logic [SRAM_WIDTH-1:0]  sram_wr_data;
   logic [31:0]            stall_cycles;

   modport master (
      input  start, num_tiles, tile_words, dma_valid, dma_data, cmp_start,
      output busy, done, dma_ready, cmp_tile_ready, sram_bank_swap, sram_rd_en, sram_rd_addr,
             sram_wr_en, sram_wr_addr, sram_wr_data, stall_cycles
   );
   modport slave (
      output start, num_tiles, tile_words, dma_valid, dma_data, cmp_start,
      input  busy, done, dma_ready, cmp_tile_ready, sram_bank_swap, sram_rd_en, sram_rd_addr,
             sram_wr_en, sram_wr_addr, sram_wr_data, stall_cycles
   );
endinterface

// File: rtl/weight_bank_scheduler.sv
// weight_bank_scheduler: fills the inactive weight bank from DMA, drains the active bank to compute,
// swaps banks when both sides are ready. Define WBS_STALL_CNT_EN to build the compute-starved counter.
module weight_bank_scheduler #(
   parameter int SRAM_ADDR_W = 10,
   parameter int SRAM_DEPTH  = 1024,
   parameter int SRAM_WIDTH  = 64
) (
   input logic                      clk,
   input logic                      rst_n,
   weight_bank_scheduler_if.master  io_bus
);
   typedef enum logic {L_IDLE, L_RUN} l_state_t;
   typedef enum logic [1:0] {D_IDLE, D_READ, D_FLUSH} d_state_t;

   localparam logic [SRAM_ADDR_W:0] DEPTH_W = (SRAM_ADDR_W+1)'(SRAM_DEPTH);

   l_state_t               r_l;
   d_state_t               r_d;
   logic [15:0]            r_num, r_loaded, r_drained;
   logic [SRAM_ADDR_W-1:0] r_tw_m1, r_wr_cnt, r_rd_cnt;
   logic                   r_fl, r_inact_full, r_act_full, r_done;
   logic [SRAM_ADDR_W:0]   w_tw;
   logic [SRAM_ADDR_W-1:0] w_tw_m1;
   logic                   w_run, w_d_idle, w_start, w_accept, w_swap;

   assign w_run    = r_l == L_RUN;
   assign w_d_idle = r_d == D_IDLE;
   assign w_start  = io_bus.start & ~w_run;
   assign w_tw     = (io_bus.tile_words == '0 || io_bus.tile_words > DEPTH_W) ? DEPTH_W : io_bus.tile_words;
   assign w_tw_m1  = SRAM_ADDR_W'(w_tw - 1'b1);
   assign w_accept = io_bus.dma_valid & io_bus.dma_ready;
   // Swap only with the read pipe empty so the controller's output mux never moves under in-flight data.
   assign w_swap   = w_run & r_inact_full & ~r_act_full & w_d_idle;

   assign io_bus.busy           = w_run;
   assign io_bus.done           = r_done;
   assign io_bus.dma_ready      = w_run & ~r_inact_full & (r_loaded < r_num);
   assign io_bus.cmp_tile_ready = r_act_full & w_d_idle;
   assign io_bus.sram_bank_swap = w_swap;
   assign io_bus.sram_wr_en     = w_accept;
   assign io_bus.sram_wr_addr   = r_wr_cnt;
   assign io_bus.sram_wr_data   = io_bus.dma_data;
   assign io_bus.sram_rd_en     = r_d == D_READ;
   assign io_bus.sram_rd_addr   = r_rd_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_l          <= L_IDLE;
         r_d          <= D_IDLE;
         r_num        <= '0;
         r_loaded     <= '0;
         r_drained    <= '0;
         r_tw_m1      <= '0;
         r_wr_cnt     <= '0;
         r_rd_cnt     <= '0;
         r_fl         <= 1'b0;
         r_inact_full <= 1'b0;
         r_act_full   <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_start) begin
            r_num        <= io_bus.num_tiles;
            r_tw_m1      <= w_tw_m1;
            r_l          <= (io_bus.num_tiles == '0) ? L_IDLE : L_RUN;
            r_done       <= io_bus.num_tiles == '0;
            r_d          <= D_IDLE;
            r_loaded     <= '0;
            r_drained    <= '0;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_fl         <= 1'b0;
            r_inact_full <= 1'b0;
            r_act_full   <= 1'b0;
         end else if (w_run) begin
            if (r_drained == r_num) begin
               r_l    <= L_IDLE;
               r_done <= 1'b1;
            end
            if (w_accept) begin
               r_wr_cnt <= (r_wr_cnt == r_tw_m1) ? '0 : r_wr_cnt + 1'b1;
               if (r_wr_cnt == r_tw_m1) begin
                  r_inact_full <= 1'b1;
                  r_loaded     <= r_loaded + 1'b1;
               end
            end
            if (w_swap) begin
               r_act_full   <= 1'b1;
               r_inact_full <= 1'b0;
            end
            case (r_d)
               D_IDLE:  if (io_bus.cmp_start & r_act_full) r_d <= D_READ;
               D_READ: begin
                  r_rd_cnt <= (r_rd_cnt == r_tw_m1) ? '0 : r_rd_cnt + 1'b1;
                  if (r_rd_cnt == r_tw_m1) r_d <= D_FLUSH;
               end
               D_FLUSH: begin
                  r_fl <= ~r_fl;
                  if (r_fl) begin
                     r_d        <= D_IDLE;
                     r_act_full <= 1'b0;
                     r_drained  <= r_drained + 1'b1;
                  end
               end
               default: r_d <= D_IDLE;
            endcase
         end
      end
   end

`ifdef WBS_STALL_CNT_EN
   logic [31:0] r_stall;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_stall <= '0;
      else if (w_start) r_stall <= '0;
      else if (w_run & ~r_act_full & w_d_idle & ~&r_stall) r_stall <= r_stall + 1'b1;
   end
   assign io_bus.stall_cycles = r_stall;
`else
   assign io_bus.stall_cycles = '0;
`endif
endmodule
